// File: rtl/bar_pkg.sv
// bar_pkg: shared defaults, height type and FSM states for bar_height_loader
package bar_pkg;
  localparam int NUM_BARS_DEF = 20;
  localparam int HEIGHT_W_DEF = 6;
  typedef logic [HEIGHT_W_DEF-1:0] height_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;
endpackage

// File: rtl/bar_height_loader_rd_valid_pipe.sv
// rd_valid_pipe: DEPTH-deep valid-token shift register tracking in-flight RAM reads
module rd_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  output logic valid_o,
  output logic empty_o
);
  logic [DEPTH-1:0] sr_q;
  // shift a token in every cycle; it emerges DEPTH cycles later
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sr_q <= '0;
    else sr_q <= DEPTH'({sr_q, push_i});
  assign valid_o = sr_q[DEPTH-1];
  assign empty_o = ~|sr_q;
endmodule

// File: rtl/bar_height_loader.sv
// bar_height_loader: burst-reads bar RAM into a shadow array and commits it atomically; PEAK_HOLD_EN enables peak-hold decay
module bar_height_loader
  import bar_pkg::*;
#(
  parameter int NUM_BARS   = NUM_BARS_DEF,
  parameter int HEIGHT_W   = HEIGHT_W_DEF,
  parameter int MAX_HEIGHT = 63,
  parameter int RAM_LAT    = 2,
  parameter int DECAY      = 1
) (
  input  logic                         CLK,
  input  logic                         reset_n,
  input  logic                         data_back,
  output logic [5:0]                   ram_rdaddress,
  input  logic [HEIGHT_W-1:0]          ram_q,
  output logic [NUM_BARS*HEIGHT_W-1:0] height,
  output logic                         control_bit,
  output logic                         update,
  output logic                         busy
);
  localparam int CW = $clog2(NUM_BARS) + 1;
  localparam logic [HEIGHT_W-1:0] MAXH = HEIGHT_W'(MAX_HEIGHT);
  localparam logic [HEIGHT_W-1:0] DEC = HEIGHT_W'(DECAY);
`ifdef PEAK_HOLD_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif

  state_t state_q, state_d;
  logic db_q, pend_q, pend_d, start, again, tok, empty, last;
  logic [CW-1:0] addr_q, addr_d, cap_q;
  logic [NUM_BARS*HEIGHT_W-1:0] shadow_q, height_q, height_d;

  function automatic logic [HEIGHT_W-1:0] hold(input logic [HEIGHT_W-1:0] s, input logic [HEIGHT_W-1:0] h);
    logic [HEIGHT_W-1:0] d;
    d = h > DEC ? h - DEC : '0;
    return (PEAK && d > s) ? d : s;
  endfunction

  assign start = data_back & ~db_q;
  assign again = pend_q | start;
  assign last = addr_q == CW'(NUM_BARS - 1);

  rd_valid_pipe #(.DEPTH(RAM_LAT)) u_pipe (
    .clk_i  (CLK),
    .rst_ni (reset_n),
    .push_i (state_q == ISSUE),
    .valid_o(tok),
    .empty_o(empty)
  );

  // next state, address counter and merged pending request
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    pend_d = pend_q | (start & (state_q != IDLE));
    case (state_q)
      IDLE: if (start) begin state_d = ISSUE; addr_d = '0; end
      ISSUE: if (last) state_d = DRAIN; else addr_d = addr_q + 1'b1;
      DRAIN: if (empty) state_d = COMMIT;
      default: begin
        state_d = again ? ISSUE : IDLE;
        addr_d = again ? '0 : addr_q;
        pend_d = 1'b0;
      end
    endcase
  end

  // committed heights: direct copy or peak-hold with decay, only in COMMIT
  always_comb begin
    height_d = height_q;
    for (int i = 0; i < NUM_BARS; i++)
      if (state_q == COMMIT)
        height_d[i*HEIGHT_W +: HEIGHT_W] = hold(shadow_q[i*HEIGHT_W +: HEIGHT_W], height_q[i*HEIGHT_W +: HEIGHT_W]);
  end

  // state, counters, saturated shadow capture and committed array
  always_ff @(posedge CLK or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      db_q <= 1'b0;
      pend_q <= 1'b0;
      addr_q <= '0;
      cap_q <= '0;
      shadow_q <= '0;
      height_q <= '0;
    end else begin
      state_q <= state_d;
      db_q <= data_back;
      pend_q <= pend_d;
      addr_q <= addr_d;
      cap_q <= (state_q == IDLE || state_q == COMMIT) ? '0 : cap_q + CW'(tok);
      for (int i = 0; i < NUM_BARS; i++)
        if (tok && cap_q == CW'(i))
          shadow_q[i*HEIGHT_W +: HEIGHT_W] <= ram_q > MAXH ? MAXH : ram_q;
      height_q <= height_d;
    end

  assign ram_rdaddress = 6'(addr_q);
  assign height = height_q;
  assign busy = state_q != IDLE;
  assign control_bit = state_q == ISSUE || state_q == DRAIN;
  assign update = state_q == COMMIT;
endmodule

// File: tb/tb_bar_height_loader.sv
// tb_bar_height_loader: directed table-driven bench with a RAM_LAT=2 RAM model
module tb_bar_height_loader;
  localparam int NB = 20;
  localparam int HW = 6;
  localparam int MH = 40;
`ifdef PEAK_HOLD_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  typedef struct {
    int base;
    int oi;
    int ov;
    int cb;
    int ce;
  } vec_t;

  logic clk = 1'b0, reset_n = 1'b0, data_back = 1'b0;
  logic [5:0] ram_rdaddress;
  logic [HW-1:0] ram_q, a1;
  logic [NB*HW-1:0] height;
  logic control_bit, update, busy;
  logic b1, c1, c24, b25;
  logic [HW-1:0] mem [64];
  int exp_h [NB];
  int checks = 0, errors = 0;
  vec_t tbl [4];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a1 <= mem[ram_rdaddress];
    ram_q <= a1;
  end

  bar_height_loader #(.NUM_BARS(NB), .HEIGHT_W(HW), .MAX_HEIGHT(MH), .RAM_LAT(2), .DECAY(1)) dut (
    .CLK(clk), .reset_n(reset_n), .data_back(data_back), .ram_rdaddress(ram_rdaddress),
    .ram_q(ram_q), .height(height), .control_bit(control_bit), .update(update), .busy(busy)
  );

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  function automatic int bar(input int i);
    return int'(height[i*HW +: HW]);
  endfunction

  task automatic load(input int base, input int oi, input int ov);
    for (int i = 0; i < 64; i++) mem[i] = (i == oi) ? 6'(ov) : 6'(base + i);
  endtask

  task automatic model_commit();
    for (int i = 0; i < NB; i++) begin
      int s, d;
      s = int'(mem[i]) > MH ? MH : int'(mem[i]);
      d = exp_h[i] > 1 ? exp_h[i] - 1 : 0;
      exp_h[i] = (PK && d > s) ? d : s;
    end
  endtask

  task automatic chk_all();
    for (int i = 0; i < NB; i++) chk($sformatf("bar%0d", i), bar(i), exp_h[i]);
  endtask

  task automatic burst(input int hold, input int e1, input int e2, input int len, output int u1, output int u2, output int n);
    int bad;
    bad = 0; u1 = -1; u2 = -1; n = 0;
    @(posedge clk);
    #1 data_back = 1'b1;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (c == hold) data_back = 1'b0;
      if (c == e1 || c == e2) data_back = 1'b1;
      if ((e1 > 0 && c == e1 + 1) || (e2 > 0 && c == e2 + 1)) data_back = 1'b0;
      if (c >= 1 && c <= NB && ram_rdaddress !== 6'(c - 1)) bad++;
      if (c == 1) begin b1 = busy; c1 = control_bit; end
      if (c == 24) c24 = control_bit;
      if (c == 25) b25 = busy;
      if (update) begin
        n++;
        if (u1 < 0) u1 = c; else if (u2 < 0) u2 = c;
      end
    end
    data_back = 1'b0;
    chk("addr_seq", bad, 0);
  endtask

  initial begin
    int u1, u2, n;
    tbl[0] = '{base: 5,  oi: -1, ov: 0,  cb: 7,  ce: 12};
    tbl[1] = '{base: 5,  oi: 3,  ov: 63, cb: 3,  ce: 40};
    tbl[2] = '{base: 10, oi: 3,  ov: 39, cb: 3,  ce: 39};
    tbl[3] = '{base: 30, oi: 0,  ov: 50, cb: 11, ce: 40};
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < NB; i++) exp_h[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_height", int'(|height), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ctl", int'(control_bit), 0);
    chk("rst_update", int'(update), 0);
    chk("rst_addr", int'(ram_rdaddress), 0);
    reset_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      load(tbl[t].base, tbl[t].oi, tbl[t].ov);
      burst(1, -1, -1, 40, u1, u2, n);
      model_commit();
      chk("upd_cycle", u1, 24);
      chk("upd_count", n, 1);
      chk("busy_c1", int'(b1), 1);
      chk("ctl_c1", int'(c1), 1);
      chk("ctl_c24", int'(c24), 0);
      chk("busy_c25", int'(b25), 0);
      chk("bar_sel", bar(tbl[t].cb), tbl[t].ce);
      chk_all();
    end
    load(7, -1, 0);
    burst(1, 5, 10, 75, u1, u2, n);
    model_commit();
    model_commit();
    chk("pend_u1", u1, 24);
    chk("pend_u2", u2, 48);
    chk("pend_n", n, 2);
    chk("pend_busy_c25", int'(b25), 1);
    chk_all();
    burst(1, 24, -1, 75, u1, u2, n);
    model_commit();
    model_commit();
    chk("commit_edge_u2", u2, 48);
    chk("commit_edge_n", n, 2);
    chk_all();
    burst(100, -1, -1, 130, u1, u2, n);
    model_commit();
    chk("held_u1", u1, 24);
    chk("held_n", n, 1);
    load(2, -1, 0);
    @(posedge clk);
    #1 data_back = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 1) data_back = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_height", int'(|height), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ctl", int'(control_bit), 0);
    chk("mid_rst_addr", int'(ram_rdaddress), 0);
    for (int i = 0; i < NB; i++) exp_h[i] = 0;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 3) reset_n = 1'b1;
      if (update) n++;
    end
    chk("mid_rst_no_update", n, 0);
    burst(1, -1, -1, 40, u1, u2, n);
    model_commit();
    chk("post_rst_u1", u1, 24);
    chk_all();
    load(0, 0, 30);
    burst(1, -1, -1, 40, u1, u2, n);
    model_commit();
    chk("peak_load", bar(0), 30);
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int k = 1; k <= 3; k++) begin
      burst(1, -1, -1, 40, u1, u2, n);
      model_commit();
      chk($sformatf("peak_decay%0d", k), bar(0), PK ? 30 - k : 0);
    end
    mem[0] = 6'd38;
    burst(1, -1, -1, 40, u1, u2, n);
    model_commit();
    chk("peak_rise", bar(0), 38);
    chk_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
